// File: rtl/if_stage_if.sv
// IF-stage bus: hazard/redirect inputs, ROM port, and the IF/ID register view.
// IF_PERF_CNT_EN adds the three perf counter signals.
interface if_stage_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);
  logic                   stall;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] id_instr;
  logic [PC_WIDTH-1:0]    id_next_pc;
  logic                   id_valid;
  logic [3:0]             id_i31_i28, id_i19_i16, id_i15_i12, id_i3_i0;
  logic [11:0]            id_i11_i0;
  logic [23:0]            id_i23_i0;
  logic [1:0]             fetch_state;
`ifdef IF_PERF_CNT_EN
  logic [15:0]            perf_fetched, perf_stalled, perf_flushed;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, id_instr, id_next_pc, id_valid,
           id_i31_i28, id_i19_i16, id_i15_i12, id_i3_i0, id_i11_i0, id_i23_i0,
           fetch_state, perf_fetched, perf_stalled, perf_flushed
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, id_instr, id_next_pc, id_valid,
           id_i31_i28, id_i19_i16, id_i15_i12, id_i3_i0, id_i11_i0, id_i23_i0,
           fetch_state, perf_fetched, perf_stalled, perf_flushed
  );
`else
  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, id_instr, id_next_pc, id_valid,
           id_i31_i28, id_i19_i16, id_i15_i12, id_i3_i0, id_i11_i0, id_i23_i0,
           fetch_state
  );
  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, id_instr, id_next_pc, id_valid,
           id_i31_i28, id_i19_i16, id_i15_i12, id_i3_i0, id_i11_i0, id_i23_i0,
           fetch_state
  );
`endif
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC, ROM addressing, IF/ID register with stall and branch flush.
// Optional saturating perf counters when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input logic       clk,
  input logic       reset,
  if_stage_if.master bus
);
  typedef enum logic [1:0] {
    S_RST   = 2'b00,
    S_RUN   = 2'b01,
    S_HOLD  = 2'b10,
    S_FLUSH = 2'b11
  } state_t;

  state_t                 r_state, w_next_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]    r_next_pc;
  logic                   r_valid;
  logic                   w_flush, w_hold, w_advance;
  logic [PC_WIDTH-1:0]    w_pc_plus4;

  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_RUN;
    if (w_flush)     w_next_state = S_FLUSH;
    else if (w_hold) w_next_state = S_HOLD;
  end

  // Branch outranks stall: a redirect must never be lost behind a hazard hold.
  always_comb begin
    w_flush   = bus.branch_taken;
    w_hold    = !bus.branch_taken && bus.stall;
    w_advance = !bus.branch_taken && !bus.stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_next_pc <= '0;
      r_valid   <= 1'b0;
    end else if (w_flush) begin
      r_pc      <= {bus.branch_target[PC_WIDTH-1:2], 2'b00};
      r_instr   <= '0;
      r_next_pc <= '0;
      r_valid   <= 1'b0;
    end else if (w_advance) begin
      r_pc      <= w_pc_plus4;
      r_instr   <= bus.imem_data;
      r_next_pc <= w_pc_plus4;
      r_valid   <= 1'b1;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.id_instr    = r_instr;
  assign bus.id_next_pc  = r_next_pc;
  assign bus.id_valid    = r_valid;
  assign bus.fetch_state = r_state;
  assign bus.id_i31_i28  = r_instr[31:28];
  assign bus.id_i19_i16  = r_instr[19:16];
  assign bus.id_i15_i12  = r_instr[15:12];
  assign bus.id_i3_i0    = r_instr[3:0];
  assign bus.id_i11_i0   = r_instr[11:0];
  assign bus.id_i23_i0   = r_instr[23:0];

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_perf_fetched, r_perf_stalled, r_perf_flushed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_stalled <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_advance && r_perf_fetched != 16'hFFFF) r_perf_fetched <= r_perf_fetched + 16'd1;
      if (w_hold    && r_perf_stalled != 16'hFFFF) r_perf_stalled <= r_perf_stalled + 16'd1;
      if (w_flush   && r_perf_flushed != 16'hFFFF) r_perf_flushed <= r_perf_flushed + 16'd1;
    end
  end

  assign bus.perf_fetched = r_perf_fetched;
  assign bus.perf_stalled = r_perf_stalled;
  assign bus.perf_flushed = r_perf_flushed;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected IF/ID state per edge,
// a negedge monitor pops and compares.
module tb_if_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_stage_if #(.PC_WIDTH(8), .INSTR_WIDTH(32)) bus ();

  if_stage #(.PC_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(8'h00)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] rom [0:63];
  assign bus.imem_data = rom[bus.imem_addr[7:2]];

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  npc;
    logic        v;
    logic [1:0]  st;
    logic [7:0]  addr;
    int          pf, ps, pl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int m_pf = 0, m_ps = 0, m_pl = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus plus the expected IF/ID view after the coming edge.
  task automatic cyc(input bit r, input bit s, input bit b, input logic [7:0] t,
                     input logic [31:0] ei, input logic [7:0] en, input bit ev,
                     input logic [1:0] es, input logic [7:0] ea);
    exp_t x;
    @(negedge clk);
    #1;
    reset = r;
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = t;
    if (r) begin m_pf = 0; m_ps = 0; m_pl = 0; end
    else if (b) m_pl++;
    else if (s) m_ps++;
    else m_pf++;
    x.instr = ei; x.npc = en; x.v = ev; x.st = es; x.addr = ea;
    x.pf = m_pf; x.ps = m_ps; x.pl = m_pl;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("id_instr",    bus.id_instr,           e.instr);
      chk("id_next_pc",  32'(bus.id_next_pc),    32'(e.npc));
      chk("id_valid",    32'(bus.id_valid),      32'(e.v));
      chk("fetch_state", 32'(bus.fetch_state),   32'(e.st));
      chk("imem_addr",   32'(bus.imem_addr),     32'(e.addr));
      chk("id_i31_i28",  32'(bus.id_i31_i28),    32'(e.instr[31:28]));
      chk("id_i19_i16",  32'(bus.id_i19_i16),    32'(e.instr[19:16]));
      chk("id_i15_i12",  32'(bus.id_i15_i12),    32'(e.instr[15:12]));
      chk("id_i3_i0",    32'(bus.id_i3_i0),      32'(e.instr[3:0]));
      chk("id_i11_i0",   32'(bus.id_i11_i0),     32'(e.instr[11:0]));
      chk("id_i23_i0",   32'(bus.id_i23_i0),     32'(e.instr[23:0]));
`ifdef IF_PERF_CNT_EN
      chk("perf_fetched", 32'(bus.perf_fetched), 32'(e.pf));
      chk("perf_stalled", 32'(bus.perf_stalled), 32'(e.ps));
      chk("perf_flushed", 32'(bus.perf_flushed), 32'(e.pl));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h9000_0000 ^ (i * 32'h0103_0507);
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 8'h00;
    //   r  s  b  tgt    instr    npc    v  st     addr
    cyc(1, 0, 0, 8'h00, 32'h0,   8'h00, 0, 2'b00, 8'h00);
    cyc(1, 0, 0, 8'h00, 32'h0,   8'h00, 0, 2'b00, 8'h00);
    cyc(0, 0, 0, 8'h00, rom[0],  8'h04, 1, 2'b01, 8'h04);
    cyc(0, 0, 0, 8'h00, rom[1],  8'h08, 1, 2'b01, 8'h08);
    cyc(0, 1, 0, 8'h00, rom[1],  8'h08, 1, 2'b10, 8'h08);
    cyc(0, 1, 0, 8'h00, rom[1],  8'h08, 1, 2'b10, 8'h08);
    cyc(0, 0, 0, 8'h00, rom[2],  8'h0C, 1, 2'b01, 8'h0C);
    cyc(0, 0, 0, 8'h00, rom[3],  8'h10, 1, 2'b01, 8'h10);
    cyc(0, 0, 1, 8'h20, 32'h0,   8'h00, 0, 2'b11, 8'h20);
    cyc(0, 0, 0, 8'h00, rom[8],  8'h24, 1, 2'b01, 8'h24);
    cyc(0, 1, 1, 8'h23, 32'h0,   8'h00, 0, 2'b11, 8'h20);
    cyc(0, 1, 0, 8'h00, 32'h0,   8'h00, 0, 2'b10, 8'h20);
    cyc(0, 0, 0, 8'h00, rom[8],  8'h24, 1, 2'b01, 8'h24);
    cyc(0, 0, 1, 8'hFC, 32'h0,   8'h00, 0, 2'b11, 8'hFC);
    cyc(0, 0, 0, 8'h00, rom[63], 8'h00, 1, 2'b01, 8'h00);
    cyc(0, 0, 0, 8'h00, rom[0],  8'h04, 1, 2'b01, 8'h04);
    cyc(1, 1, 1, 8'h40, 32'h0,   8'h00, 0, 2'b00, 8'h00);
    cyc(0, 0, 0, 8'h00, rom[0],  8'h04, 1, 2'b01, 8'h04);
    cyc(0, 0, 0, 8'h00, rom[1],  8'h08, 1, 2'b01, 8'h08);
    cyc(0, 0, 1, 8'h20, 32'h0,   8'h00, 0, 2'b11, 8'h20);
    cyc(0, 0, 0, 8'h00, rom[8],  8'h24, 1, 2'b01, 8'h24);
    cyc(0, 0, 0, 8'h00, rom[9],  8'h28, 1, 2'b01, 8'h28);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
